// File: rtl/manquehuito_pkg.sv
// Shared types and constants for the fetch path: address type, instruction width,
// reset address and the queued fetch entry.
package manquehuito_pkg;

    localparam int unsigned INSTR_W = 16;

    typedef logic [7:0] addr_t;

    localparam addr_t RESET_PC = 8'h00;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        addr_t              addr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO of fetched instructions with flush; head is shown combinationally.
module fetch_fifo
    import manquehuito_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output logic [1:0]   count,
    output logic         head_valid,
    output fetch_entry_t head
);

    fetch_entry_t mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic         pop_eff;

    assign pop_eff    = pop & (count_q != 2'd0);
    assign count      = count_q;
    assign head_valid = (count_q != 2'd0);
    assign head       = mem_q[rd_ptr_q];

    // When full, a simultaneous push/pop writes the slot being vacated by the head.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else if (flush) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_eff) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop_eff};
        end
    end

    always @(posedge clk) begin
        if (!rst && !flush && push && !pop_eff) begin
            assert (count_q != 2'd2);
        end
    end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: drives ROM from the PC, stalls/redirects the PC through
// its load port, and queues returned instructions for the decoder.
module ifetch_ctrl #(
    parameter int unsigned INSTR_W  = 16,
    parameter logic [7:0]  RESET_PC = 8'h00
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [7:0]         pc_i,
    output logic               pc_load_o,
    output logic [7:0]         pc_im_o,
    output logic [7:0]         imem_addr_o,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    input  logic               jmp_i,
    input  logic [7:0]         jmp_target_i,
    output logic               instr_valid_o,
    input  logic               instr_ready_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [7:0]         instr_pc_o
);

    import manquehuito_pkg::*;

    logic         pop;
    logic         issue;
    logic [2:0]   occupancy;
    logic         inflight_q;
    addr_t        inflight_addr_q;
    logic [1:0]   count;
    logic         head_valid;
    fetch_entry_t head;
    fetch_entry_t wentry;

    assign imem_addr_o = pc_i;
    assign pop         = instr_valid_o & instr_ready_i;

    // Slots already committed (queued + in flight) after this cycle's pop.
    always_comb begin
        occupancy = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
        issue     = (occupancy < 3'd2) && !jmp_i && !rst_i;
    end

    always_comb begin
        pc_load_o = 1'b1;
        pc_im_o   = pc_i;
        if (rst_i) begin
            pc_im_o = RESET_PC;
        end else if (jmp_i) begin
            pc_im_o = jmp_target_i;
        end else if (issue) begin
            pc_load_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                inflight_addr_q <= pc_i;
            end
        end
    end

    always_comb begin
        wentry.instr = imem_rdata_i;
        wentry.addr  = inflight_addr_q;
    end

    fetch_fifo u_fifo (
        .clk        (clk_i),
        .rst        (rst_i),
        .push       (inflight_q & ~jmp_i),
        .pop        (pop & ~jmp_i),
        .flush      (jmp_i),
        .wdata      (wentry),
        .count      (count),
        .head_valid (head_valid),
        .head       (head)
    );

    assign instr_valid_o = head_valid;
    assign instr_o       = head.instr;
    assign instr_pc_o    = head.addr;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Randomized scoreboard bench for ifetch_ctrl, with a PC/ROM environment model and
// directed latency, stall, jump, wrap and reset checks.
module tb_ifetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jmp = 1'b0;
    logic [7:0]  tgt = 8'h00;
    logic        ready = 1'b0;
    logic        pc_load;
    logic [7:0]  pc_im;
    logic [7:0]  imem_addr;
    logic        valid;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic [7:0]  pc;
    logic [15:0] rom_q;

    always #5 clk = ~clk;

    ifetch_ctrl #(
        .INSTR_W  (16),
        .RESET_PC (8'h00)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .pc_i          (pc),
        .pc_load_o     (pc_load),
        .pc_im_o       (pc_im),
        .imem_addr_o   (imem_addr),
        .imem_rdata_i  (rom_q),
        .jmp_i         (jmp),
        .jmp_target_i  (tgt),
        .instr_valid_o (valid),
        .instr_ready_i (ready),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc)
    );

    // Environment: 8-bit PC with load port and a 1-cycle ROM holding A000 + address.
    always @(posedge clk) begin
        pc    <= pc_load ? pc_im : pc + 8'd1;
        rom_q <= 16'hA000 + {8'h00, imem_addr};
    end

    int         n_checks  = 0;
    int         n_fail    = 0;
    int         delivered = 0;
    logic [7:0] exp_q[$];
    logic [7:0] next_addr = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Program-order model: the decoder must see consecutive addresses from the last
    // redirect point, regardless of timing.
    task automatic redirect(input logic [7:0] a);
        exp_q.delete();
        next_addr = a;
    endtask

    task automatic step(input logic r, input logic j, input logic [7:0] t, input logic rdy);
        @(posedge clk);
        #1;
        rst   = r;
        jmp   = j;
        tgt   = t;
        ready = rdy;
        if (r) redirect(8'h00);
        else if (j) redirect(t);
        while (exp_q.size() < 4) begin
            exp_q.push_back(next_addr);
            next_addr = next_addr + 8'd1;
        end
    endtask

    // Monitor: scoreboard pops on accepted handshakes, plus head stability under stall.
    logic        prev_hold = 1'b0;
    logic [7:0]  prev_pc   = 8'h00;
    logic [15:0] prev_ins  = 16'h0000;

    always @(negedge clk) begin
        logic [7:0] e;
        if (prev_hold) begin
            check("hold_valid", 32'(valid), 32'(1));
            check("hold_pc", 32'(instr_pc), 32'(prev_pc));
            check("hold_instr", 32'(instr), 32'(prev_ins));
        end
        prev_hold = !rst && !jmp && valid && !ready;
        prev_pc   = instr_pc;
        prev_ins  = instr;
        if (!rst && !jmp && valid && ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL deliver_empty: got pc %0h, expected no delivery", instr_pc);
            end else begin
                e = exp_q.pop_front();
                check("deliver_pc", 32'(instr_pc), 32'(e));
                check("deliver_instr", 32'(instr), 32'(16'hA000 + {8'h00, e}));
                delivered++;
            end
        end
    end

    task automatic wait_head(input logic [7:0] a);
        bit found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (valid && instr_pc == a && ready) begin
                found = 1'b1;
                break;
            end
            step(1'b0, 1'b0, 8'h00, 1'b1);
            @(negedge clk);
        end
        check("wait_head_found", 32'(found), 32'(1));
    endtask

    task automatic jump_check(input logic [7:0] a, input logic rdy_j, input string nm);
        step(1'b0, 1'b1, a, rdy_j);
        @(negedge clk);
        check({nm, "_jmp_load"}, 32'(pc_load), 32'(1));
        check({nm, "_jmp_im"}, 32'(pc_im), 32'(a));
        step(1'b0, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        check({nm, "_t1_valid"}, 32'(valid), 32'(0));
        check({nm, "_t1_pc"}, 32'(pc), 32'(a));
        step(1'b0, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        check({nm, "_t2_valid"}, 32'(valid), 32'(0));
        step(1'b0, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        check({nm, "_t3_valid"}, 32'(valid), 32'(1));
        check({nm, "_t3_pc"}, 32'(instr_pc), 32'(a));
    endtask

    initial begin
        // Reset held 3 cycles.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        check("rst_pc_load", 32'(pc_load), 32'(1));
        check("rst_pc_im", 32'(pc_im), 32'(8'h00));
        check("rst_valid", 32'(valid), 32'(0));
        check("rst_instr", 32'(instr), 32'(0));
        check("rst_instr_pc", 32'(instr_pc), 32'(0));
        check("rst_imem_addr", 32'(imem_addr), 32'(pc));

        // First fetch: valid rises in cycle 2, then one per cycle.
        step(1'b0, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        check("first_c0_valid", 32'(valid), 32'(0));
        check("first_c0_issue", 32'(pc_load), 32'(0));
        step(1'b0, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        check("first_c1_valid", 32'(valid), 32'(0));
        step(1'b0, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        check("first_c2_valid", 32'(valid), 32'(1));
        check("first_c2_pc", 32'(instr_pc), 32'(8'h00));
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
            @(negedge clk);
            check("throughput_valid", 32'(valid), 32'(1));
        end

        // Backpressure starting with 04 at the head.
        wait_head(8'h03);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b0);
            @(negedge clk);
        end
        check("bp_head", 32'(instr_pc), 32'(8'h04));
        check("bp_pc_load", 32'(pc_load), 32'(1));
        check("bp_pc_im", 32'(pc_im), 32'(8'h06));
        check("bp_pc", 32'(pc), 32'(8'h06));
        step(1'b0, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        check("bp_resume_issue", 32'(pc_load), 32'(0));

        // Jump while 10,11 queued.
        wait_head(8'h0F);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        jump_check(8'h40, 1'b1, "jump");

        // Jump during a full-queue stall.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check("stall_load", 32'(pc_load), 32'(1));
        check("stall_im", 32'(pc_im), 32'(pc));
        jump_check(8'h20, 1'b0, "jstall");

        // Wrap past FF.
        jump_check(8'hFE, 1'b1, "wrap");
        wait_head(8'h01);

        // Reset mid-stream with a full queue.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check("mrst_load", 32'(pc_load), 32'(1));
        check("mrst_im", 32'(pc_im), 32'(8'h00));
        step(1'b0, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        check("mrst_c0_valid", 32'(valid), 32'(0));
        step(1'b0, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        check("mrst_c1_valid", 32'(valid), 32'(0));
        step(1'b0, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        check("mrst_c2_valid", 32'(valid), 32'(1));
        check("mrst_c2_pc", 32'(instr_pc), 32'(8'h00));

        // Random traffic.
        delivered = 0;
        for (int i = 0; i < 600; i++) begin
            logic r;
            logic j;
            r = ($urandom % 100) == 0;
            j = !r && (($urandom % 16) == 0);
            step(r, j, 8'($urandom), ($urandom % 4) != 0);
            @(negedge clk);
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
            @(negedge clk);
        end
        check("random_progress", 32'(delivered > 150), 32'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
